// File: rtl/async_fifo_read_ctrl_if.sv
// Read-side bundle of an async FIFO: write-pointer input, memory read port and consumer handshake.
// almost_empty exists only when FIFO_RD_ALMOST_EMPTY_EN is defined.
interface async_fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;
  logic                  empty;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic                  almost_empty;
`endif

  modport master (
    input  wptr_gray, mem_rdata, rready,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    output almost_empty,
`endif
    output rptr_gray, raddr, ren, rdata, rvalid, empty
  );

  modport slave (
    output wptr_gray, mem_rdata, rready,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    input  almost_empty,
`endif
    input  rptr_gray, raddr, ren, rdata, rvalid, empty
  );
endinterface

// File: rtl/async_fifo_read_ctrl.sv
// Read-domain controller of an async FIFO: synchronizes the Gray write pointer, owns the read pointer and flags.
// Optional almost_empty flag is built when FIFO_RD_ALMOST_EMPTY_EN is defined.
module async_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AE_THRESH  = 4
) (
  input  logic                   rclk,
  input  logic                   rrst,
  async_fifo_read_ctrl_if.master bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wq1_q, wq1_d;
  logic [PW-1:0]         wq2_q, wq2_d;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rgray_q, rgray_d;
  logic                  empty_q, empty_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  if (AE_THRESH < 0 || AE_THRESH > (2 ** ADDR_WIDTH)) begin : g_bad_ae_thresh
    $error("AE_THRESH must lie within 0..2**ADDR_WIDTH");
  end

  always_comb begin
    wq1_d    = bus.wptr_gray;
    wq2_d    = wq1_q;
    // Reads stall while a presented word waits for the consumer, so mem_rdata holds steady.
    ren      = !empty_q && (!rvalid_q || bus.rready);
    rbin_d   = rbin_q + {{ADDR_WIDTH{1'b0}}, ren};
    rgray_d  = bin2gray(rbin_d);
    // Compare against the next pointer so empty rises on the edge that takes the last word.
    empty_d  = (rgray_d == wq2_q);
    rvalid_d = rvalid_q;
    if (ren) begin
      rvalid_d = 1'b1;
    end else if (bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1_q    <= '0;
      wq2_q    <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      wq1_q    <= wq1_d;
      wq2_q    <= wq2_d;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      empty_q  <= empty_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] fill;
  logic          ae_q, ae_d;

  // Fill level seen after this edge's read; modulo wrap keeps it correct across pointer rollover.
  always_comb begin
    wbin_s = gray2bin(wq2_q);
    fill   = wbin_s - rbin_d;
    ae_d   = (32'(fill) <= 32'(AE_THRESH));
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ae_q <= 1'b1;
    end else begin
      ae_q <= ae_d;
    end
  end

  assign bus.almost_empty = ae_q;
`endif

  assign rdata         = bus.mem_rdata;
  assign bus.rdata     = rdata;
  assign bus.rptr_gray = rgray_q;
  assign bus.raddr     = rbin_q[ADDR_WIDTH-1:0];
  assign bus.ren       = ren;
  assign bus.rvalid    = rvalid_q;
  assign bus.empty     = empty_q;
endmodule

// File: doc/async_fifo_read_ctrl.md
ASYNC_FIFO_READ_CTRL -- requirements
Module: async_fifo_read_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, memory address width (depth 2**ADDR_WIDTH).
REQ-003 The block SHALL have parameter AE_THRESH, default 4, almost-empty level in words.
REQ-004 The block SHALL have port rclk  input  1  read-domain clock, rising edge.
REQ-005 The block SHALL have port rrst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port wptr_gray  input  ADDR_WIDTH+1  write pointer, Gray-coded, from the write clock domain (asynchronous).
REQ-007 The block SHALL have port rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
REQ-008 The block SHALL have port raddr  output  ADDR_WIDTH  memory read address, equal to the binary read pointer's low ADDR_WIDTH bits.
REQ-009 The block SHALL have port ren  output  1  memory read enable, combinational.
REQ-010 The block SHALL have port mem_rdata  input  DATA_WIDTH  registered memory read data, valid one rclk after ren.
REQ-011 The block SHALL have port rdata  output  DATA_WIDTH  consumer data, equal to mem_rdata.
REQ-012 The block SHALL have port rvalid  output  1  rdata holds an unconsumed word.
REQ-013 The block SHALL have port rready  input  1  consumer accepts rdata.
REQ-014 The block SHALL have port empty  output  1  registered FIFO-empty flag.
REQ-015 The block SHALL have port almost_empty  output  1  registered; present only under FIFO_RD_ALMOST_EMPTY_EN.

Function
REQ-016 wptr_gray SHALL pass through a two-flop rclk synchronizer (wq1, wq2) before any use.
REQ-017 The block SHALL keep a binary read pointer rbin of ADDR_WIDTH+1 bits, wrapping modulo 2**(ADDR_WIDTH+1), with rptr_gray = rbin ^ (rbin >> 1), both registered.
REQ-018 ren SHALL equal !empty && (!rvalid || rready).
REQ-019 When ren=1, rbin SHALL increment by 1 on the next rclk edge; otherwise rbin SHALL hold.
REQ-020 empty SHALL be registered as (Gray of next rbin) == wq2, so empty asserts on the edge that consumes the last word.
REQ-021 rvalid SHALL be set on the rclk edge after ren=1, and cleared on an edge where rvalid && rready && !ren.
REQ-022 When rvalid=1 and rready=0, ren SHALL be 0, so the memory holds mem_rdata and rdata stays stable.
REQ-023 Latency: a wptr_gray change SHALL deassert empty on the 3rd rclk edge after it, and rvalid SHALL follow one edge after the resulting ren.
REQ-024 Full-depth wrap: after 2**ADDR_WIDTH reads, raddr SHALL return to 0 and the MSB of rbin SHALL toggle.
REQ-025 Back-to-back throughput SHALL be one word per rclk while !empty and rready=1.
REQ-026 On a simultaneous write arrival and last-word read, empty SHALL assert for at least one cycle and then deassert per REQ-023.

Reset
REQ-027 While rrst=1, the block SHALL force rbin=0, rptr_gray=0, wq1=wq2=0, rvalid=0, empty=1, almost_empty=1, and therefore ren=0.
REQ-028 rrst asserted mid-transfer SHALL drop rvalid immediately (asynchronously) and discard any in-flight word.
REQ-029 Reset release SHALL be synchronized externally, and the first ren SHALL occur no earlier than 3 edges after a nonzero wptr_gray.

Configuration
REQ-030 With macro FIFO_RD_ALMOST_EMPTY_EN defined, the block SHALL convert wq2 to binary wbin_s and register almost_empty = ((wbin_s - next rbin) mod 2**(ADDR_WIDTH+1)) <= AE_THRESH.
REQ-031 Without FIFO_RD_ALMOST_EMPTY_EN, the almost_empty port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DATA_WIDTH=8, ADDR_WIDTH=5, AE_THRESH=4)
REQ-032 Reset: rrst=1 then released with wptr_gray=0 -> empty=1, rvalid=0, ren=0, raddr=0, rptr_gray=0 for 10 cycles.
REQ-033 Single word: wptr_gray 0->1, rready=1 -> empty=0 at the 3rd edge, ren=1 one cycle with raddr=0, rvalid=1 next cycle with rdata=mem[0], then empty=1.
REQ-034 Backpressure: 3 words written, rready=0 -> rvalid=1, ren=0, and rdata constant for 20 cycles; then rready=1 -> 3 words delivered on consecutive cycles in order.
REQ-035 Wrap: 70 words streamed with rready=1 -> raddr sequence 0..31,0..31,0..5, rptr_gray MSB toggles at reads 32 and 64, no loss or duplication.
REQ-036 Almost empty (macro on): 6 words present, almost_empty=0; after 2 reads (4 left) -> almost_empty=1; bench without macro compiles and passes REQ-032..035.
REQ-037 Reset mid-stream: rrst pulsed while rvalid=1 -> rvalid=0 in the same cycle, with all state as in REQ-027.
